// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C engine among NUM_REQ clients.
// The owner keeps the bus from START to STOP; each instruction is watchdog-limited.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     cmd_en,
  input  logic [2*NUM_REQ-1:0]   cmd_instr,
  input  logic [8*NUM_REQ-1:0]   cmd_byte,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [7:0]             rx_byte,
  output logic [1:0]             i2cInstruction,
  output logic                   i2cEnable,
  output logic [7:0]             i2cByteToSend,
  input  logic [7:0]             i2cByteReceived,
  input  logic                   i2cComplete
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [IdxW-1:0]    LastInit = IdxW'(NUM_REQ - 1);
  localparam logic [CntW-1:0]    WdLimit  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] OneHot0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    StIdle,
    StOwned,
    StBusy,
    StWaitEnLow
  } stateT;

  stateT           state;
  logic [IdxW-1:0] owner;
  logic [IdxW-1:0] last;
  logic            started;
  logic [CntW-1:0] wdCount;

  logic [IdxW-1:0] pick;
  logic            ownEn;
  logic            ownReq;
  logic [1:0]      ownInstr;
  logic [7:0]      ownByte;

  // Scan from farthest to nearest so the first requester after `last` wins.
  always_comb begin
    pick = last;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      logic [IdxW-1:0] cand;
      cand = IdxW'((int'(last) + k) % int'(NUM_REQ));
      if (req[cand]) begin
        pick = cand;
      end
    end
  end

  assign ownEn    = cmd_en[owner];
  assign ownReq   = req[owner];
  assign ownInstr = cmd_instr[{owner, 1'b0} +: 2];
  assign ownByte  = cmd_byte[{owner, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      owner          <= '0;
      last           <= LastInit;
      started        <= 1'b0;
      wdCount        <= '0;
      grant          <= '0;
      done           <= '0;
      err            <= 1'b0;
      rx_byte        <= '0;
      i2cInstruction <= '0;
      i2cEnable      <= 1'b0;
      i2cByteToSend  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        StIdle: begin
          if (|req) begin
            owner <= pick;
            last  <= pick;
            grant <= OneHot0 << pick;
            state <= StOwned;
          end
        end
        StOwned: begin
          if (ownEn) begin
            i2cInstruction <= ownInstr;
            i2cByteToSend  <= ownByte;
            i2cEnable      <= 1'b1;
            started        <= 1'b0;
            wdCount        <= '0;
            state          <= StBusy;
          end else if (!ownReq) begin
            grant <= '0;
            state <= StIdle;
          end
        end
        StBusy: begin
          // A complete that is still high from the previous op does not count until it has dropped.
          if (!i2cComplete) begin
            started <= 1'b1;
          end
          if (started && i2cComplete) begin
            i2cEnable <= 1'b0;
            rx_byte   <= i2cByteReceived;
            done      <= OneHot0 << owner;
            state     <= StWaitEnLow;
          end else if (wdCount == WdLimit) begin
            i2cEnable <= 1'b0;
            done      <= OneHot0 << owner;
            err       <= 1'b1;
            grant     <= '0;
            state     <= StIdle;
          end else begin
            wdCount <= wdCount + 1'b1;
          end
        end
        StWaitEnLow: begin
          if (!ownEn) begin
            state <= StOwned;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: engine model, done/grant scoreboards, per-feature tests.
module tb_i2c_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     cmd_en;
  logic [2*N-1:0]   cmd_instr;
  logic [8*N-1:0]   cmd_byte;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic             err;
  logic [7:0]       rx_byte;
  logic [1:0]       i2cInstruction;
  logic             i2cEnable;
  logic [7:0]       i2cByteToSend;
  logic [7:0]       i2cByteReceived = 8'h00;
  logic             i2cComplete = 1'b1;

  i2c_bus_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .cmd_en          (cmd_en),
    .cmd_instr       (cmd_instr),
    .cmd_byte        (cmd_byte),
    .grant           (grant),
    .done            (done),
    .err             (err),
    .rx_byte         (rx_byte),
    .i2cInstruction  (i2cInstruction),
    .i2cEnable       (i2cEnable),
    .i2cByteToSend   (i2cByteToSend),
    .i2cByteReceived (i2cByteReceived),
    .i2cComplete     (i2cComplete)
  );

  always #5 clk = ~clk;

  // Engine model. Mode 0: normal, 1: complete stays high 3 extra cycles, 2: never completes.
  int         engMode  = 0;
  logic [1:0] engPhase = 2'd0;
  int         engCnt   = 0;
  logic [9:0] engLog[$];

  always @(posedge clk) begin
    case (engPhase)
      2'd0: if (i2cEnable) begin
        engLog.push_back({i2cInstruction, i2cByteToSend});
        engCnt <= 3;
        if (engMode == 1) begin
          engPhase <= 2'd1;
        end else begin
          i2cComplete <= 1'b0;
          engPhase    <= 2'd2;
        end
      end
      2'd1: if (!i2cEnable) begin
        engPhase <= 2'd0;
      end else if (engCnt == 1) begin
        i2cComplete <= 1'b0;
        engCnt      <= 3;
        engPhase    <= 2'd2;
      end else begin
        engCnt <= engCnt - 1;
      end
      2'd2: if (!i2cEnable) begin
        i2cComplete <= 1'b1;
        engPhase    <= 2'd0;
      end else if (engMode != 2) begin
        if (engCnt == 1) begin
          i2cComplete     <= 1'b1;
          i2cByteReceived <= (i2cInstruction == 2'd2) ? 8'h1A : 8'hEE;
          engPhase        <= 2'd3;
        end else begin
          engCnt <= engCnt - 1;
        end
      end
      default: if (!i2cEnable) engPhase <= 2'd0;
    endcase
  end

  typedef struct {
    int         client;
    bit         isErr;
    bit         chkRx;
    logic [7:0] rx;
  } doneExpT;

  doneExpT expDone[$];
  int      expGrant[$];
  int      total;
  int      bad;

  task automatic pushDone(input int c, input bit e, input bit chk);
    doneExpT d;
    d.client = c;
    d.isErr  = e;
    d.chkRx  = chk;
    d.rx     = 8'h1A;
    expDone.push_back(d);
  endtask

  // Scoreboard: compare the current done pulse against the oldest expectation.
  task automatic popDone();
    doneExpT      d;
    logic [N-1:0] expOh;
    total++;
    if (expDone.size() == 0) begin
      bad++;
      $display("FAIL done_unexpected got=%b exp=none", done);
      return;
    end
    d = expDone.pop_front();
    expOh = '0;
    expOh[d.client] = 1'b1;
    if (done !== expOh) begin
      bad++;
      $display("FAIL done_owner got=%b exp=%b", done, expOh);
    end
    total++;
    if (err !== d.isErr) begin
      bad++;
      $display("FAIL err_flag got=%b exp=%b", err, d.isErr);
    end
    if (d.chkRx) begin
      total++;
      if (rx_byte !== d.rx) begin
        bad++;
        $display("FAIL rx_byte got=%h exp=%h", rx_byte, d.rx);
      end
    end
  endtask

  task automatic waitDone(input int limit);
    int      n;
    doneExpT dummy;
    n = 0;
    while (done === '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done === '0) begin
      total++;
      bad++;
      $display("FAIL done_timeout got=none exp=pulse within %0d cycles", limit);
      if (expDone.size() > 0) dummy = expDone.pop_front();
    end else begin
      popDone();
    end
  endtask

  task automatic waitGrant(input int limit);
    int           n;
    int           c;
    logic [N-1:0] expOh;
    n = 0;
    while (grant === '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (expGrant.size() == 0) begin
      bad++;
      $display("FAIL grant_unexpected got=%b exp=none", grant);
      return;
    end
    c = expGrant.pop_front();
    expOh = '0;
    expOh[c] = 1'b1;
    if (grant !== expOh) begin
      bad++;
      $display("FAIL grant_order got=%b exp=%b", grant, expOh);
    end
  endtask

  task automatic doCmd(input int c, input logic [1:0] ins, input logic [7:0] b);
    pushDone(c, 1'b0, ins == 2'd2);
    cmd_instr[2*c +: 2] = ins;
    cmd_byte[8*c +: 8]  = b;
    cmd_en[c]           = 1'b1;
    waitDone(100);
    cmd_en[c] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = '0;
    cmd_en    = '0;
    cmd_instr = '0;
    cmd_byte  = '0;
    repeat (2) @(negedge clk);
    total += 4;
    if (grant !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", grant); end
    if ({done, err} !== '0) begin bad++; $display("FAIL rst_done got=%b exp=0", {done, err}); end
    if (i2cEnable !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", i2cEnable); end
    if ({rx_byte, i2cInstruction, i2cByteToSend} !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h exp=0", {rx_byte, i2cInstruction, i2cByteToSend});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== '0) begin bad++; $display("FAIL idle_grant got=%b exp=0", grant); end
  endtask

  task automatic test_single();
    logic [1:0] ins[4];
    logic [7:0] byt[4];
    logic [9:0] expLog;
    ins = '{2'd0, 2'd3, 2'd2, 2'd1};
    byt = '{8'h00, 8'h91, 8'h00, 8'h00};
    engLog.delete();
    expGrant.push_back(0);
    req[0] = 1'b1;
    @(negedge clk);
    waitGrant(0);
    // First instruction checks enable latency explicitly.
    pushDone(0, 1'b0, 1'b0);
    cmd_instr[1:0] = ins[0];
    cmd_byte[7:0]  = byt[0];
    cmd_en[0]      = 1'b1;
    @(negedge clk);
    total++;
    if (i2cEnable !== 1'b1) begin bad++; $display("FAIL en_latency got=%b exp=1", i2cEnable); end
    waitDone(100);
    cmd_en[0] = 1'b0;
    @(negedge clk);
    for (int i = 1; i < 4; i++) begin
      doCmd(0, ins[i], byt[i]);
      total++;
      if (grant !== 4'b0001) begin bad++; $display("FAIL single_hold got=%b exp=0001", grant); end
    end
    total++;
    if (engLog.size() != 4) begin
      bad++;
      $display("FAIL single_engine_count got=%0d exp=4", engLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        expLog = {ins[i], byt[i]};
        total++;
        if (engLog[i] !== expLog) begin
          bad++;
          $display("FAIL single_engine_op got=%h exp=%h", engLog[i], expLog);
        end
      end
    end
    req[0] = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== '0) begin bad++; $display("FAIL single_release got=%b exp=0", grant); end
  endtask

  task automatic test_round_robin();
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) expGrant.push_back(order[i]);
    req = '1;
    for (int i = 0; i < 5; i++) begin
      waitGrant(20);
      total++;
      if ($countones(grant) != 1) begin
        bad++;
        $display("FAIL rr_onehot got=%b exp=one bit", grant);
      end
      if (i == 1) req[0] = 1'b1;
      doCmd(order[i], 2'd0, 8'h00);
      doCmd(order[i], 2'd1, 8'h00);
      req[order[i]] = 1'b0;
      @(negedge clk);
      total++;
      if (grant !== '0) begin bad++; $display("FAIL rr_release got=%b exp=0", grant); end
    end
  endtask

  task automatic test_contention();
    logic [9:0] expLog[3];
    expLog = '{{2'd0, 8'h02}, {2'd3, 8'hC2}, {2'd1, 8'h02}};
    expGrant.push_back(2);
    req[2] = 1'b1;
    waitGrant(10);
    engLog.delete();
    req[1]            = 1'b1;
    cmd_instr[3:2]    = 2'd3;
    cmd_byte[15:8]    = 8'h55;
    cmd_en[1]         = 1'b1;
    doCmd(2, 2'd0, 8'h02);
    doCmd(2, 2'd3, 8'hC2);
    doCmd(2, 2'd1, 8'h02);
    total++;
    if (engLog.size() != 3) begin
      bad++;
      $display("FAIL cont_engine_count got=%0d exp=3", engLog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (engLog[i] !== expLog[i]) begin
          bad++;
          $display("FAIL cont_engine_op got=%h exp=%h", engLog[i], expLog[i]);
        end
      end
    end
    pushDone(1, 1'b0, 1'b0);
    expGrant.push_back(1);
    req[2] = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== '0) begin bad++; $display("FAIL cont_gap got=%b exp=0", grant); end
    @(negedge clk);
    waitGrant(0);
    waitDone(100);
    cmd_en[1] = 1'b0;
    @(negedge clk);
    total++;
    if (engLog.size() != 4 || engLog[engLog.size()-1] !== {2'd3, 8'h55}) begin
      bad++;
      $display("FAIL cont_client1_op got=%0d entries exp=4 ending 355", engLog.size());
    end
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stale_complete();
    int n;
    bit sawLow;
    expGrant.push_back(3);
    req[3] = 1'b1;
    waitGrant(10);
    engMode = 1;
    pushDone(3, 1'b0, 1'b1);
    cmd_instr[7:6] = 2'd2;
    cmd_en[3]      = 1'b1;
    n      = 0;
    sawLow = 1'b0;
    while (done === '0 && n < 100) begin
      @(negedge clk);
      n++;
      if (done === '0 && !i2cComplete) sawLow = 1'b1;
    end
    total++;
    if (!sawLow) begin
      bad++;
      $display("FAIL stale_early_done got=done before complete fell exp=after fall");
    end
    popDone();
    cmd_en[3] = 1'b0;
    @(negedge clk);
    req[3] = 1'b0;
    engMode = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    expGrant.push_back(0);
    req[0] = 1'b1;
    waitGrant(10);
    engMode = 2;
    pushDone(0, 1'b1, 1'b0);
    cmd_instr[1:0] = 2'd3;
    cmd_en[0]      = 1'b1;
    @(negedge clk);
    total++;
    if (i2cEnable !== 1'b1) begin bad++; $display("FAIL wd_en_rise got=%b exp=1", i2cEnable); end
    n = 0;
    while (done === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != TO) begin bad++; $display("FAIL wd_latency got=%0d exp=%0d", n, TO); end
    total++;
    if (i2cEnable !== 1'b0) begin bad++; $display("FAIL wd_en_drop got=%b exp=0", i2cEnable); end
    popDone();
    cmd_en[0] = 1'b0;
    req[0]    = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== '0) begin bad++; $display("FAIL wd_grant got=%b exp=0", grant); end
    engMode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    expGrant.push_back(1);
    req[1] = 1'b1;
    waitGrant(10);
    engMode = 2;
    cmd_instr[3:2] = 2'd0;
    cmd_en[1]      = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (i2cEnable !== 1'b1) begin bad++; $display("FAIL rb_busy got=%b exp=1", i2cEnable); end
    rst = 1'b1;
    #1;
    total += 3;
    if (grant !== '0) begin bad++; $display("FAIL rb_grant got=%b exp=0", grant); end
    if (i2cEnable !== 1'b0) begin bad++; $display("FAIL rb_en got=%b exp=0", i2cEnable); end
    if ({done, err, rx_byte, i2cInstruction, i2cByteToSend} !== '0) begin
      bad++;
      $display("FAIL rb_outputs got=%h exp=0", {done, err, rx_byte, i2cInstruction, i2cByteToSend});
    end
    cmd_en  = '0;
    req     = '0;
    engMode = 0;
    repeat (2) @(negedge clk);
    expGrant.push_back(3);
    rst = 1'b0;
    req = 4'b1000;
    waitGrant(5);
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_stale_complete();
    test_timeout();
    test_reset_busy();
    total++;
    if (expDone.size() != 0 || expGrant.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", expDone.size(), expGrant.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
